dcache_coherence_ctrl: RTL

- Per-core data-cache controller: the cache-side end of the snooping bus that the memory controller arbitrates.
- Serves CPU loads and stores from a direct-mapped MSI cache.
- On a miss, requests the bus: writes back the dirty victim, then fills.
- As a snoop responder, supplies M data and downgrades or invalidates lines on ccwait, ccsnoopaddr and ccinv.
- One instance per core, in the caches wrapper.

---
 rtl/cpu_types_pkg.sv | 51 +++++
 rtl/dcache_snoop_fsm.sv | 91 +++++++++
 rtl/dcache_coherence_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types for the data cache.
//
// Contents:
//   word_t          32-bit data word.
//   msi_t           per-line coherence state {I, S, M}.
//   dcache_frame_t  one direct-mapped frame: tag, MSI state, two data words.
//   req_state_t     requester (miss-handling) FSM states.
//   snoop_state_t   snoop responder FSM states.
//   DCACHE_SETS     default number of sets.
//   DCACHE_TAGW     stored tag width.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int DCACHE_SETS = 8;

    // The tag is addr >> (3 + log2(SETS)). With at least two sets that is
    // never wider than 28 bits, so 29 bits covers every legal SETS value.
    // Unused upper bits simply stay zero.
    localparam int DCACHE_TAGW = 29;

    typedef enum logic [1:0] {
        I,
        S,
        M
    } msi_t;

    typedef struct packed {
        logic [DCACHE_TAGW-1:0] tag;
        msi_t                   state;
        word_t [1:0]            data;
    } dcache_frame_t;

    typedef enum logic [2:0] {
        R_IDLE,
        WB0,
        WB1,
        LD0,
        LD1,
        UPD
    } req_state_t;

    typedef enum logic [2:0] {
        SN_IDLE,
        SN_LOOK,
        SN_W0,
        SN_W1,
        SN_APPLY
    } snoop_state_t;

endpackage

// File: rtl/dcache_snoop_fsm.sv
// Snoop responder FSM for the data cache.
//
// It sequences one snoop transaction. In SN_LOOK it registers the lookup
// result that the top computes from ccsnoopaddr. It then steps through the
// two block words on ccinv pulses and requests the final state change.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   ccwait_i         snoop in progress for this cache
//   ccinv_i          invalidate request (in SN_LOOK) / per-word done pulse
//   idx_i            set index of the snooped address
//   hit_i, hitM_i    combinational lookup of the snooped address
//   busy_o           FSM is not in SN_IDLE
//   ccwrite_o        lookup not yet resolved (SN_LOOK)
//   supply_o         supplying M data this cycle (drives cctrans)
//   supplyWord_o     which block word is being supplied
//   applyEn_o        apply the state change to the matching line
//   applyInv_o       change is an invalidate (else downgrade M to S)
//   idx_o            registered set index of the snooped line
module dcache_snoop_fsm
    import cpu_types_pkg::*;
#(
    parameter int IDXW = 3
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            ccwait_i,
    input  logic            ccinv_i,
    input  logic [IDXW-1:0] idx_i,
    input  logic            hit_i,
    input  logic            hitM_i,
    output logic            busy_o,
    output logic            ccwrite_o,
    output logic            supply_o,
    output logic            supplyWord_o,
    output logic            applyEn_o,
    output logic            applyInv_o,
    output logic [IDXW-1:0] idx_o
);

    snoop_state_t    state_q, state_d;
    logic            hit_q, hitM_q, inv_q;
    logic [IDXW-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= SN_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The lookup is frozen in SN_LOOK. A snoop miss still walks the word
    // states so that the bus sees the expected ccinv handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_q  <= 1'b0;
            hitM_q <= 1'b0;
            inv_q  <= 1'b0;
            idx_q  <= '0;
        end else if (state_q == SN_LOOK) begin
            hit_q  <= hit_i;
            hitM_q <= hitM_i;
            inv_q  <= ccinv_i;
            idx_q  <= idx_i;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SN_IDLE:  if (ccwait_i) state_d = SN_LOOK;
            SN_LOOK:  state_d = SN_W0;
            SN_W0:    if (ccinv_i && !ccwait_i) state_d = SN_W1;
            SN_W1:    if (ccinv_i && !ccwait_i) state_d = SN_APPLY;
            SN_APPLY: state_d = SN_IDLE;
            default:  state_d = SN_IDLE;
        endcase
    end

    always_comb begin
        busy_o       = (state_q != SN_IDLE);
        ccwrite_o    = (state_q == SN_LOOK);
        supply_o     = hitM_q && ((state_q == SN_W0) || (state_q == SN_W1));
        supplyWord_o = (state_q == SN_W1);
        applyEn_o    = (state_q == SN_APPLY) && hit_q;
        applyInv_o   = inv_q;
        idx_o        = idx_q;
    end

endmodule

// File: rtl/dcache_coherence_ctrl.sv
// Per-core direct-mapped MSI data cache controller.
//
// CPU loads and stores that hit are served combinationally. A miss runs the
// requester FSM: an optional two-word writeback of a dirty victim, then a
// two-word fill. The fill ends in UPD, which installs the line; the CPU then
// retries and hits. Snoops are handled by dcache_snoop_fsm. Snoops take
// priority over the CPU: while a snoop is active, dhit is forced low and the
// requester FSM holds its state and outputs.
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   dmemREN/WEN/addr/store         CPU request (held until dhit)
//   dhit, dmemload                 CPU completion and load data
//   dREN, dWEN, daddr, dstore      bus fill / writeback request
//   dwait, dload                   bus word handshake and fill data
//   ccwait, ccinv, ccsnoopaddr     snoop request from the bus
//   ccwrite, cctrans               snoop lookup pending / M request or supply
module dcache_coherence_ctrl
    import cpu_types_pkg::*;
#(
    parameter int SETS = DCACHE_SETS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic        dwait,
    input  logic [31:0] dload,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr,
    output logic        ccwrite,
    output logic        cctrans
);

    localparam int IDXW = $clog2(SETS);

    function automatic logic [DCACHE_TAGW-1:0] tagOf(input word_t a);
        return DCACHE_TAGW'(a >> (3 + IDXW));
    endfunction

    dcache_frame_t          frame_q [SETS];
    dcache_frame_t          frame_d [SETS];
    req_state_t             rState_q, rState_d;
    word_t                  fill0_q, fill1_q;

    logic [IDXW-1:0]        reqIdx, snIdx, snHeldIdx;
    logic [DCACHE_TAGW-1:0] reqTag, snTag;
    logic                   reqWord;
    dcache_frame_t          reqLine, snLine;
    logic                   cpuReq, tagMatch, cpuHit;
    logic                   snHit, snHitM;
    word_t                  reqBase, vicBase;

    logic snBusy, snSupply, snWord, snApply, snInv;

    assign reqIdx  = dmemaddr[IDXW+2:3];
    assign reqWord = dmemaddr[2];
    assign reqTag  = tagOf(dmemaddr);
    assign reqLine = frame_q[reqIdx];
    assign snIdx   = ccsnoopaddr[IDXW+2:3];
    assign snTag   = tagOf(ccsnoopaddr);
    assign snLine  = frame_q[snIdx];

    // A store needs the line in M. A store to an S or I line is a miss and
    // refills the block with cctrans set to gain ownership.
    assign cpuReq   = dmemREN || dmemWEN;
    assign tagMatch = (reqLine.state != I) && (reqLine.tag == reqTag);
    assign cpuHit   = dmemWEN ? (tagMatch && (reqLine.state == M)) : tagMatch;
    assign snHit    = (snLine.state != I) && (snLine.tag == snTag);
    assign snHitM   = snHit && (snLine.state == M);

    assign reqBase = {dmemaddr[31:3], 3'b000};
    assign vicBase = (word_t'(reqLine.tag) << (3 + IDXW)) | (word_t'(reqIdx) << 3);

    dcache_snoop_fsm #(.IDXW(IDXW)) u_snoop (
        .clk_i        (CLK),
        .rst_ni       (nRST),
        .ccwait_i     (ccwait),
        .ccinv_i      (ccinv),
        .idx_i        (snIdx),
        .hit_i        (snHit),
        .hitM_i       (snHitM),
        .busy_o       (snBusy),
        .ccwrite_o    (ccwrite),
        .supply_o     (snSupply),
        .supplyWord_o (snWord),
        .applyEn_o    (snApply),
        .applyInv_o   (snInv),
        .idx_o        (snHeldIdx)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rState_q <= R_IDLE;
        end else begin
            rState_q <= rState_d;
        end
    end

    always_comb begin
        rState_d = rState_q;
        if (!snBusy) begin
            unique case (rState_q)
                R_IDLE: if (cpuReq && !cpuHit)
                    rState_d = ((reqLine.state == M) && (reqLine.tag != reqTag)) ? WB0 : LD0;
                WB0:     if (!dwait) rState_d = WB1;
                WB1:     if (!dwait) rState_d = LD0;
                LD0:     if (!dwait) rState_d = LD1;
                LD1:     if (!dwait) rState_d = UPD;
                UPD:     rState_d = R_IDLE;
                default: rState_d = R_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fill0_q <= '0;
            fill1_q <= '0;
        end else if (!snBusy && !dwait) begin
            if (rState_q == LD0) fill0_q <= dload;
            if (rState_q == LD1) fill1_q <= dload;
        end
    end

    // The three frame updates are mutually exclusive: UPD and store hits
    // only happen while the snoop FSM is idle, and snoop apply only while it
    // is busy. A snoop can change a victim's state during a writeback, but it
    // never touches the data, so the writeback still sends the same words.
    always_comb begin
        frame_d = frame_q;
        if ((rState_q == UPD) && !snBusy) begin
            frame_d[reqIdx].tag     = reqTag;
            frame_d[reqIdx].state   = dmemWEN ? M : S;
            frame_d[reqIdx].data[0] = fill0_q;
            frame_d[reqIdx].data[1] = fill1_q;
            if (dmemWEN) frame_d[reqIdx].data[reqWord] = dmemstore;
        end else if (snApply) begin
            if (snInv) begin
                frame_d[snHeldIdx].state = I;
            end else if (frame_q[snHeldIdx].state == M) begin
                frame_d[snHeldIdx].state = S;
            end
        end else if (dhit && dmemWEN) begin
            frame_d[reqIdx].data[reqWord] = dmemstore;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++) frame_q[i] <= '0;
        end else begin
            frame_q <= frame_d;
        end
    end

    always_comb begin
        dhit     = cpuReq && cpuHit && (rState_q == R_IDLE) && !snBusy;
        dmemload = dhit ? reqLine.data[reqWord] : '0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        daddr    = '0;
        dstore   = '0;
        cctrans  = 1'b0;
        unique case (rState_q)
            WB0: begin
                dWEN   = 1'b1;
                daddr  = vicBase;
                dstore = reqLine.data[0];
            end
            WB1: begin
                dWEN   = 1'b1;
                daddr  = vicBase | 32'd4;
                dstore = reqLine.data[1];
            end
            LD0: begin
                dREN    = 1'b1;
                daddr   = reqBase;
                cctrans = dmemWEN;
            end
            LD1: begin
                dREN    = 1'b1;
                daddr   = reqBase | 32'd4;
                cctrans = dmemWEN;
            end
            default: ;
        endcase
        if (snSupply) begin
            cctrans = 1'b1;
            dstore  = frame_q[snHeldIdx].data[snWord];
        end
    end

endmodule
